// File: rtl/readout_scheduler.sv
// Readout frame sequencer: on an overflow or manual request it walks the counter mux
// through the RTC word and every enabled channel, pulsing PISO load/shift, then clears the counters.
module readout_scheduler #(
   parameter int N_SRC      = 16,
   parameter int SEL_W      = 4,
   parameter int WORD_W     = 12,
   parameter int RST_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ovf,
   input  logic             trig,
   input  logic [N_SRC-1:0] ch_mask,
   output logic [SEL_W-1:0] selection,
   output logic             SL,
   output logic             rst,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             ovf_missed,
   output logic [SEL_W-1:0] word_count
);

   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      LOAD,
      SHIFT,
      CLEAR,
      WAIT_LOW
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [BC_W-1:0]    bitCnt_q, bitCnt_d;
   logic [RC_W-1:0]    rstCnt_q, rstCnt_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [SEL_W-1:0]   wordCount_q, wordCount_d;
   logic               missed_q, missed_d;

   logic               ovfMeta_q, ovfSync_q, ovfSyncDly_q;
   logic               ovfRise, req;

   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               sl_q, sl_d;
   logic               rst_q, rst_d;
   logic               bitValid_q, bitValid_d;
   logic               busy_q, busy_d;

   logic [SEL_W-1:0]   nextIdx;
   logic               nextFound;

   assign ovfRise = ovfSync_q & ~ovfSyncDly_q;
   assign req     = ovfRise | trig;

   // Lowest enabled source strictly above the current one; bit 0 never qualifies since idx >= 0.
   always_comb begin
      nextIdx   = '0;
      nextFound = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (mask_q[i] && (SEL_W'(i) > idx_q)) begin
            nextIdx   = SEL_W'(i);
            nextFound = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         bitCnt_q     <= '0;
         rstCnt_q     <= '0;
         mask_q       <= '0;
         wordCount_q  <= '0;
         missed_q     <= 1'b0;
         ovfMeta_q    <= 1'b0;
         ovfSync_q    <= 1'b0;
         ovfSyncDly_q <= 1'b0;
         sel_q        <= '0;
         sl_q         <= 1'b0;
         rst_q        <= 1'b0;
         bitValid_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         bitCnt_q     <= bitCnt_d;
         rstCnt_q     <= rstCnt_d;
         mask_q       <= mask_d;
         wordCount_q  <= wordCount_d;
         missed_q     <= missed_d;
         ovfMeta_q    <= ovf;
         ovfSync_q    <= ovfMeta_q;
         ovfSyncDly_q <= ovfSync_q;
         sel_q        <= sel_d;
         sl_q         <= sl_d;
         rst_q        <= rst_d;
         bitValid_q   <= bitValid_d;
         busy_q       <= busy_d;
      end
   end

   // Outputs are registered copies of what the next state will present, so they line up with state_q.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      bitCnt_d    = bitCnt_q;
      rstCnt_d    = rstCnt_q;
      mask_d      = mask_q;
      wordCount_d = wordCount_q;
      missed_d    = missed_q;

      if (req && (state_q != IDLE)) begin
         missed_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d     = ARM;
               mask_d      = ch_mask | N_SRC'(1);
               idx_d       = '0;
               wordCount_d = '0;
            end
         end
         ARM: begin
            state_d  = LOAD;
            bitCnt_d = '0;
         end
         LOAD: begin
            state_d  = SHIFT;
            bitCnt_d = '0;
         end
         SHIFT: begin
            if (bitCnt_q == BC_W'(WORD_W - 1)) begin
               wordCount_d = wordCount_q + SEL_W'(1);
               bitCnt_d    = '0;
               if (nextFound) begin
                  idx_d   = nextIdx;
                  state_d = LOAD;
               end else begin
                  rstCnt_d = '0;
                  state_d  = CLEAR;
               end
            end else begin
               bitCnt_d = bitCnt_q + BC_W'(1);
            end
         end
         CLEAR: begin
            if (rstCnt_q == RC_W'(RST_CYCLES - 1)) begin
               state_d = WAIT_LOW;
            end else begin
               rstCnt_d = rstCnt_q + RC_W'(1);
            end
         end
         WAIT_LOW: begin
            if (!ovfSync_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sl_d       = (state_d == LOAD);
      bitValid_d = (state_d == SHIFT);
      rst_d      = (state_d == CLEAR);
      busy_d     = (state_d != IDLE);
      sel_d      = ((state_d == LOAD) || (state_d == SHIFT)) ? idx_d : '0;
   end

   assign selection   = sel_q;
   assign SL          = sl_q;
   assign rst         = rst_q;
   assign bit_valid   = bitValid_q;
   assign busy        = busy_q;
   assign ovf_missed  = missed_q;
   assign word_count  = wordCount_q;
   assign frame_start = (state_q == LOAD) && (idx_q == '0);

endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: table of frame requests, a load-order scoreboard,
// plus hand-written sequences for mid-frame reset.
module tb_readout_scheduler;

   logic        clk;
   logic        reset;
   logic        ovf;
   logic        trig;
   logic [15:0] ch_mask;
   logic [3:0]  selection;
   logic        SL;
   logic        rst;
   logic        bit_valid;
   logic        frame_start;
   logic        busy;
   logic        ovf_missed;
   logic [3:0]  word_count;

   int checks = 0;
   int errors = 0;
   int bvCount = 0;
   int rstCount = 0;
   logic [3:0] selQ[$];

   typedef struct {
      logic        useOvf;
      logic [15:0] mask;
      logic [15:0] lateMask;
      int          extraTrigAt;
      logic [3:0]  expWc;
      logic        expMissed;
   } vec_t;

   vec_t vecs[7];

   readout_scheduler #(
      .N_SRC(16),
      .SEL_W(4),
      .WORD_W(12),
      .RST_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ovf(ovf),
      .trig(trig),
      .ch_mask(ch_mask),
      .selection(selection),
      .SL(SL),
      .rst(rst),
      .bit_valid(bit_valid),
      .frame_start(frame_start),
      .busy(busy),
      .ovf_missed(ovf_missed),
      .word_count(word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Each parallel load must match the next expected select, in order.
   always @(negedge clk) begin
      logic [3:0] expSel;
      if (bit_valid) bvCount++;
      if (rst) rstCount++;
      if (SL) begin
         checkOutput("load expected", int'(selQ.size() != 0), 1);
         if (selQ.size() != 0) begin
            expSel = selQ.pop_front();
            checkOutput("load selection", int'(selection), int'(expSel));
            checkOutput("frame_start on load", int'(frame_start), int'(expSel == 4'd0));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " selection"}, int'(selection), 0);
      checkOutput({tag, " SL"}, int'(SL), 0);
      checkOutput({tag, " rst"}, int'(rst), 0);
      checkOutput({tag, " bit_valid"}, int'(bit_valid), 0);
      checkOutput({tag, " frame_start"}, int'(frame_start), 0);
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " ovf_missed"}, int'(ovf_missed), 0);
      checkOutput({tag, " word_count"}, int'(word_count), 0);
   endtask

   task automatic applyStimulus(input vec_t v);
      int w;
      int lat;
      int frameLen;
      int rc;
      int c;
      w = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 0 || v.mask[i]) begin
            selQ.push_back(4'(i));
            w++;
         end
      end
      bvCount = 0;
      rstCount = 0;
      ch_mask = v.mask;
      if (v.useOvf) ovf = 1'b1;
      else trig = 1'b1;

      lat = 0;
      do begin
         step();
         lat++;
         trig = 1'b0;
      end while (!SL && lat < 12);
      checkOutput("request to load latency", lat, v.useOvf ? 4 : 2);

      frameLen = 0;
      while (!rst && frameLen < 400) begin
         if (frameLen == 1) ch_mask = v.lateMask;
         trig = (frameLen == v.extraTrigAt);
         frameLen++;
         step();
      end
      trig = 1'b0;
      checkOutput("frame length", frameLen, w * 13);
      checkOutput("bit_valid cycles", bvCount, w * 12);

      rc = 0;
      while (rst && rc < 10) begin
         rc++;
         step();
      end
      checkOutput("clear pulse width", rc, 2);
      checkOutput("word_count", int'(word_count), int'(v.expWc));
      checkOutput("busy in WAIT_LOW", int'(busy), 1);

      if (v.useOvf) begin
         repeat (5) step();
         checkOutput("held in WAIT_LOW while ovf high", int'(busy), 1);
         ovf = 1'b0;
         c = 0;
         do begin
            step();
            c++;
         end while (busy && c < 10);
         checkOutput("ovf low to idle", c, 3);
      end else begin
         step();
         checkOutput("trig frame idle after WAIT_LOW", int'(busy), 0);
      end

      repeat (20) step();
      checkOutput("no extra frame", int'(busy), 0);
      checkOutput("ovf_missed", int'(ovf_missed), int'(v.expMissed));
      checkOutput("all loads seen", selQ.size(), 0);
      checkOutput("clear pulses total", rstCount, 2);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      vecs[0] = '{1'b0, 16'h0000, 16'h0000, -1, 4'd1, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, -1, 4'd0, 1'b0};
      vecs[2] = '{1'b1, 16'h8012, 16'h8012, -1, 4'd4, 1'b0};
      vecs[3] = '{1'b0, 16'h00A5, 16'h00A5, -1, 4'd4, 1'b0};
      vecs[4] = '{1'b0, 16'h0002, 16'hFFFF, -1, 4'd2, 1'b0};
      vecs[5] = '{1'b0, 16'h4001, 16'h4001, -1, 4'd2, 1'b0};
      vecs[6] = '{1'b0, 16'h8012, 16'h8012, 30, 4'd4, 1'b1};

      reset = 1'b0;
      ovf = 1'b0;
      trig = 1'b0;
      ch_mask = 16'h0000;
      repeat (3) step();
      checkResetOutputs("reset");
      reset = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         repeat (3) step();
      end

      // Abort a frame with reset during the first word's shift: no clear pulse may follow.
      rstCount = 0;
      selQ.push_back(4'd0);
      ch_mask = 16'hFFFF;
      trig = 1'b1;
      step();
      trig = 1'b0;
      c = 0;
      while (!bit_valid && c < 10) begin
         step();
         c++;
      end
      checkOutput("shift reached before abort", int'(bit_valid), 1);
      repeat (3) step();
      reset = 1'b0;
      step();
      checkResetOutputs("mid-frame reset");
      reset = 1'b1;
      repeat (20) step();
      checkOutput("no clear after abort", rstCount, 0);
      checkOutput("idle after abort", int'(busy), 0);
      checkOutput("aborted loads consumed", selQ.size(), 0);

      applyStimulus(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
